// File: rtl/mem_mod_cycle_seq.sv
// Core-memory access cycle sequencer.
// Latches a module/sector selection on an access strobe, then runs a
// destructive-read / regenerate-write cycle: read drive with a sense strobe,
// an optional recovery gap with all drives off, and a write drive whose
// inhibit line restores (or overwrites) the bit. Every output is registered.
module mem_mod_cycle_seq #(
    parameter int RD_CYC  = 4,   // read-drive length in clocks (1..15)
    parameter int STB_POS = 2,   // read clock (1-based) carrying STROBE (1..RD_CYC)
    parameter int GAP_CYC = 1,   // recovery clocks between read and write (0..15)
    parameter int WR_CYC  = 4    // write-drive length in clocks (1..15)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mstart,
    input  logic       mzon,
    input  logic       mttn,
    input  logic       mffn,
    input  logic       mssn,
    input  logic       dman,
    input  logic       dmbn,
    input  logic       iman,
    input  logic       imbn,
    input  logic       wreq,
    input  logic       wdata,
    input  logic       sense,
    output logic [3:0] modsel,
    output logic       seca,
    output logic       secb,
    output logic       rddrv,
    output logic       wrdrv,
    output logic       inhibit,
    output logic       strobe,
    output logic       rdata,
    output logic       rvalid,
    output logic       busy,
    output logic       done,
    output logic       selerr,
    output logic       ovrerr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_GAP   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] RD_CNT  = 4'(RD_CYC);
    localparam logic [3:0] STB_CNT = 4'(STB_POS);
    localparam logic [3:0] GAP_CNT = 4'(GAP_CYC);
    localparam logic [3:0] WR_CNT  = 4'(WR_CYC);
    localparam bit         HAS_GAP = (GAP_CYC > 0);

    // Sequencer state
    state_t     state_reg;
    logic [3:0] cnt_reg;       // clocks left in the current state, including this one
    logic [3:0] rd_pos_reg;    // 1-based index of the current read clock

    // Latched access fields
    logic [3:0] modsel_reg;
    logic       seca_reg;
    logic       secb_reg;
    logic       wreq_reg;
    logic       wdata_reg;

    // Registered outputs
    logic       rddrv_reg;
    logic       wrdrv_reg;
    logic       inhibit_reg;
    logic       strobe_reg;
    logic       rdata_reg;
    logic       rvalid_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       selerr_reg;
    logic       ovrerr_reg;

    // Selection decode (inputs are active low; module vector [0]=MZ .. [3]=MS)
    logic [3:0] mod_act;
    logic [3:0] mod_sel_n;
    logic       sec_a_req;
    logic       sec_b_req;
    logic       sel_legal;

    // Write data chosen for the inhibit line
    logic       regen_bit;
    logic       inhibit_val;

    assign mod_sel_n = {mssn, mffn, mttn, mzon};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mod_act
            assign mod_act[gi] = ~mod_sel_n[gi];
        end
    endgenerate

    assign sec_a_req = ~dman | ~iman;
    assign sec_b_req = ~dmbn | ~imbn;
    assign sel_legal = $onehot(mod_act) && (sec_a_req != sec_b_req);

    // When the strobe sits in the last read clock, the sensed bit is being
    // captured on the same edge that starts the write, so take it straight
    // from the sense amp rather than from the not-yet-updated RDATA register.
    assign regen_bit   = strobe_reg ? sense : rdata_reg;
    assign inhibit_val = ~(wreq_reg ? wdata_reg : regen_bit);

    // Cycle sequencer: state, timing counter, latched fields and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            rd_pos_reg  <= 4'd0;
            modsel_reg  <= 4'd0;
            seca_reg    <= 1'b0;
            secb_reg    <= 1'b0;
            wreq_reg    <= 1'b0;
            wdata_reg   <= 1'b0;
            rddrv_reg   <= 1'b0;
            wrdrv_reg   <= 1'b0;
            inhibit_reg <= 1'b0;
            strobe_reg  <= 1'b0;
            rdata_reg   <= 1'b0;
            rvalid_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            selerr_reg  <= 1'b0;
            ovrerr_reg  <= 1'b0;
        end else begin
            // Single-clock pulses default low; RVALID trails STROBE by one clock
            strobe_reg <= 1'b0;
            done_reg   <= 1'b0;
            ovrerr_reg <= 1'b0;
            rvalid_reg <= strobe_reg;
            if (strobe_reg) begin
                rdata_reg <= sense;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (mstart) begin
                        if (sel_legal) begin
                            modsel_reg <= mod_act;
                            seca_reg   <= sec_a_req;
                            secb_reg   <= sec_b_req;
                            wreq_reg   <= wreq;
                            wdata_reg  <= wdata;
                            selerr_reg <= 1'b0;
                            state_reg  <= ST_READ;
                            cnt_reg    <= RD_CNT;
                            rd_pos_reg <= 4'd1;
                            rddrv_reg  <= 1'b1;
                            busy_reg   <= 1'b1;
                            strobe_reg <= (STB_CNT == 4'd1);
                        end else begin
                            selerr_reg <= 1'b1;
                        end
                    end
                end

                ST_READ: begin
                    ovrerr_reg <= mstart;
                    if (cnt_reg == 4'd1) begin
                        rddrv_reg <= 1'b0;
                        if (HAS_GAP) begin
                            state_reg <= ST_GAP;
                            cnt_reg   <= GAP_CNT;
                        end else begin
                            state_reg   <= ST_WRITE;
                            cnt_reg     <= WR_CNT;
                            wrdrv_reg   <= 1'b1;
                            inhibit_reg <= inhibit_val;
                        end
                    end else begin
                        cnt_reg    <= cnt_reg - 4'd1;
                        rd_pos_reg <= rd_pos_reg + 4'd1;
                        strobe_reg <= ((rd_pos_reg + 4'd1) == STB_CNT);
                    end
                end

                ST_GAP: begin
                    ovrerr_reg <= mstart;
                    if (cnt_reg == 4'd1) begin
                        state_reg   <= ST_WRITE;
                        cnt_reg     <= WR_CNT;
                        wrdrv_reg   <= 1'b1;
                        inhibit_reg <= inhibit_val;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                ST_WRITE: begin
                    ovrerr_reg <= mstart;
                    if (cnt_reg == 4'd1) begin
                        state_reg   <= ST_IDLE;
                        cnt_reg     <= 4'd0;
                        wrdrv_reg   <= 1'b0;
                        inhibit_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        modsel_reg  <= 4'd0;
                        seca_reg    <= 1'b0;
                        secb_reg    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign modsel  = modsel_reg;
    assign seca    = seca_reg;
    assign secb    = secb_reg;
    assign rddrv   = rddrv_reg;
    assign wrdrv   = wrdrv_reg;
    assign inhibit = inhibit_reg;
    assign strobe  = strobe_reg;
    assign rdata   = rdata_reg;
    assign rvalid  = rvalid_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign selerr  = selerr_reg;
    assign ovrerr  = ovrerr_reg;

endmodule
